// File: rtl/rrf_flag_wr_sched_pkg.sv
// Shared constants and types for the retirement flag register file write scheduler.
package rrf_flag_wr_sched_pkg;
  localparam int FLAG_W  = 6;
  localparam int NTHREAD = 2;
  localparam int NSLOT   = 3;

  typedef logic [FLAG_W-1:0] flag_t;
endpackage

// File: rtl/rrf_flag_coalesce.sv
// Combinational newest-slot-per-thread selector: for each thread, the highest
// retiring slot targeting it supplies the coalesced flag value.
module rrf_flag_coalesce
  import rrf_flag_wr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = FLAG_W,
  parameter int NSLOT      = rrf_flag_wr_sched_pkg::NSLOT
) (
  input  logic [NSLOT-1:0]                    ret_en,
  input  logic [NSLOT-1:0]                    ret_thread,
  input  logic [NSLOT*DATA_WIDTH-1:0]         ret_data,
  output logic [NTHREAD-1:0]                  new_v,
  output logic [NTHREAD-1:0][DATA_WIDTH-1:0]  new_d
);

  genvar gi;
  generate
    for (gi = 0; gi < NTHREAD; gi++) begin : g_thread
      logic                  sel_v;
      logic [DATA_WIDTH-1:0] sel_d;

      // Later slots are younger, so scanning upward lets the newest win.
      always_comb begin
        sel_v = 1'b0;
        sel_d = '0;
        for (int s = 0; s < NSLOT; s++) begin
          if (ret_en[s] && (ret_thread[s] == 1'(gi))) begin
            sel_v = 1'b1;
            sel_d = ret_data[s*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      assign new_v[gi] = sel_v;
      assign new_d[gi] = sel_d;
    end
  endgenerate

endmodule

// File: rtl/rrf_flag_wr_sched.sv
// Flag RRF write scheduler: per-thread pending registers, round-robin use of
// the single RRF write port, and a bypass of pending values onto the read path.
module rrf_flag_wr_sched
  import rrf_flag_wr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = FLAG_W,
  parameter int NSLOT      = rrf_flag_wr_sched_pkg::NSLOT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NSLOT-1:0]              ret_en,
  input  logic [NSLOT-1:0]              ret_thread,
  input  logic [NSLOT*DATA_WIDTH-1:0]   ret_data,
  input  logic                          wr_stall,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_wen,
  output logic                          wr_thread,
  input  logic                          rd_thread,
  input  logic [DATA_WIDTH-1:0]         rrf_rd_data,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [NTHREAD-1:0]            pend,
  output logic                          idle
);

  logic [NTHREAD-1:0]                  new_v;
  logic [NTHREAD-1:0][DATA_WIDTH-1:0]  new_d;

  logic [NTHREAD-1:0]                  pend_v_reg;
  logic [NTHREAD-1:0][DATA_WIDTH-1:0]  pend_d_reg;
  logic                                rr_reg;

  logic                                gnt_v;
  logic                                gnt;

  rrf_flag_coalesce #(
    .DATA_WIDTH (DATA_WIDTH),
    .NSLOT      (NSLOT)
  ) u_coalesce (
    .ret_en     (ret_en),
    .ret_thread (ret_thread),
    .ret_data   (ret_data),
    .new_v      (new_v),
    .new_d      (new_d)
  );

  // Round-robin only matters when both threads are waiting.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = 1'b0;
    if (!wr_stall) begin
      case (pend_v_reg)
        2'b01:   begin gnt_v = 1'b1; gnt = 1'b0;   end
        2'b10:   begin gnt_v = 1'b1; gnt = 1'b1;   end
        2'b11:   begin gnt_v = 1'b1; gnt = rr_reg; end
        default: begin gnt_v = 1'b0; gnt = 1'b0;   end
      endcase
    end
  end

  // A same-cycle retire overrides the clear: the granted (older) value goes to
  // the RRF while the newer one stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_reg <= '0;
      pend_d_reg <= '0;
      rr_reg     <= 1'b0;
    end else begin
      for (int t = 0; t < NTHREAD; t++) begin
        if (new_v[t]) begin
          pend_v_reg[t] <= 1'b1;
          pend_d_reg[t] <= new_d[t];
        end else if (gnt_v && (gnt == 1'(t))) begin
          pend_v_reg[t] <= 1'b0;
        end
      end
      if (gnt_v) begin
        rr_reg <= ~gnt;
      end
    end
  end

  assign wr_wen    = gnt_v;
  assign wr_thread = gnt_v ? gnt : 1'b0;
  assign wr_data   = gnt_v ? pend_d_reg[gnt] : '0;

  assign rd_data = pend_v_reg[rd_thread] ? pend_d_reg[rd_thread] : rrf_rd_data;
  assign pend    = pend_v_reg;
  assign idle    = ~|pend_v_reg;

endmodule

// File: tb/tb_rrf_flag_wr_sched.sv
// Directed bench for rrf_flag_wr_sched; expected RRF writes go through a scoreboard queue.
module tb_rrf_flag_wr_sched;
  localparam int DW = 6;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] ret_en;
  logic [NS-1:0] ret_thread;
  logic [NS*DW-1:0] ret_data;
  logic          wr_stall;
  logic [DW-1:0] wr_data;
  logic          wr_wen;
  logic          wr_thread;
  logic          rd_thread;
  logic [DW-1:0] rrf_rd_data;
  logic [DW-1:0] rd_data;
  logic [1:0]    pend;
  logic          idle;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  rrf_flag_wr_sched #(.DATA_WIDTH(DW), .NSLOT(NS)) dut (
    .clk         (clk),
    .rst         (rst),
    .ret_en      (ret_en),
    .ret_thread  (ret_thread),
    .ret_data    (ret_data),
    .wr_stall    (wr_stall),
    .wr_data     (wr_data),
    .wr_wen      (wr_wen),
    .wr_thread   (wr_thread),
    .rd_thread   (rd_thread),
    .rrf_rd_data (rrf_rd_data),
    .rd_data     (rd_data),
    .pend        (pend),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input logic [2:0] en, input logic [2:0] thr,
                         input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2);
    ret_en     = en;
    ret_thread = thr;
    ret_data   = {d2, d1, d0};
  endtask

  task automatic push(input logic thr, input logic [5:0] d);
    exp_q.push_back({thr, d});
  endtask

  // Scoreboard: every observed RRF write must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", {1'b0, wr_thread, wr_data}, 8'hFF);
        end else begin
          logic [6:0] e;
          e = exp_q.pop_front();
          chk("wr_thread_data", {1'b0, wr_thread, wr_data}, {1'b0, e});
          $display("write: thread=%0d data=0x%02h", wr_thread, wr_data);
        end
      end else begin
        chk("wr_idle_zero", {1'b0, wr_wen, wr_thread, wr_data}, 8'h00);
      end
    end
  end

  initial begin
    rst = 1'b1; wr_stall = 1'b0; rd_thread = 1'b0; rrf_rd_data = 6'h2A;
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pend", {6'd0, pend}, 8'h00);
    chk("rst_idle", {7'd0, idle}, 8'h01);
    chk("rst_wen", {7'd0, wr_wen}, 8'h00);
    chk("rst_bypass", {2'd0, rd_data}, 8'h2A);

    // Single retire, written the next cycle.
    set_ret(3'b001, 3'b000, 6'h15, 6'h00, 6'h00);
    push(1'b0, 6'h15);
    tick();
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    #1;
    chk("t1_pend", {6'd0, pend}, 8'h01);
    chk("t1_wen", {7'd0, wr_wen}, 8'h01);
    chk("t1_bypass", {2'd0, rd_data}, 8'h15);
    tick();
    chk("t1_idle", {7'd0, idle}, 8'h01);

    // Coalescing across slots; rr cleared by reset so t0 goes first.
    rst = 1'b1; tick(); rst = 1'b0;
    set_ret(3'b111, 3'b011, 6'h01, 6'h02, 6'h3F);
    push(1'b0, 6'h3F); push(1'b1, 6'h02);
    tick();
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    #1;
    chk("co_pend", {6'd0, pend}, 8'h03);
    chk("co_first", {7'd0, wr_thread}, 8'h00);
    tick();
    chk("co_pend2", {6'd0, pend}, 8'h02);
    tick();
    chk("co_idle", {7'd0, idle}, 8'h01);

    // Make rr=1 with a t0 write, then have both threads pending.
    set_ret(3'b001, 3'b000, 6'h05, 6'h00, 6'h00);
    push(1'b0, 6'h05);
    tick();
    set_ret(3'b011, 3'b010, 6'h06, 6'h07, 6'h00);
    push(1'b1, 6'h07); push(1'b0, 6'h06);
    tick();
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    #1;
    chk("rr_pend", {6'd0, pend}, 8'h03);
    chk("rr_t1", {7'd0, wr_thread}, 8'h01);
    tick();
    chk("rr_t0", {7'd0, wr_thread}, 8'h00);
    tick();
    chk("rr_idle", {7'd0, idle}, 8'h01);

    // Retire into a thread while its previous value is being written.
    set_ret(3'b001, 3'b000, 6'h0A, 6'h00, 6'h00);
    push(1'b0, 6'h0A);
    tick();
    set_ret(3'b010, 3'b000, 6'h00, 6'h0B, 6'h00);
    push(1'b0, 6'h0B);
    #1;
    chk("ov_data_old", {2'd0, wr_data}, 8'h0A);
    tick();
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    #1;
    chk("ov_pend", {6'd0, pend}, 8'h01);
    chk("ov_data_new", {2'd0, wr_data}, 8'h0B);
    tick();
    chk("ov_idle", {7'd0, idle}, 8'h01);

    // Four stall cycles; only the newest t1 value is written afterwards.
    wr_stall = 1'b1; rd_thread = 1'b1;
    set_ret(3'b001, 3'b001, 6'h11, 6'h00, 6'h00);
    tick();
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    #1;
    chk("st_wen0", {7'd0, wr_wen}, 8'h00);
    chk("st_rd11", {2'd0, rd_data}, 8'h11);
    tick();
    set_ret(3'b001, 3'b001, 6'h22, 6'h00, 6'h00);
    #1;
    chk("st_rd_no_cur", {2'd0, rd_data}, 8'h11);
    tick();
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    #1;
    chk("st_rd22", {2'd0, rd_data}, 8'h22);
    chk("st_pend", {6'd0, pend}, 8'h02);
    push(1'b1, 6'h22);
    tick();
    wr_stall = 1'b0;
    #1;
    chk("st_release", {7'd0, wr_wen}, 8'h01);
    tick();
    chk("st_idle", {7'd0, idle}, 8'h01);

    // Reset with both threads pending discards everything.
    wr_stall = 1'b1;
    set_ret(3'b011, 3'b010, 6'h33, 6'h2C, 6'h00);
    tick();
    set_ret(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    #1;
    chk("rp_pend", {6'd0, pend}, 8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0; wr_stall = 1'b0; rrf_rd_data = 6'h1B;
    #1;
    chk("rp_pend0", {6'd0, pend}, 8'h00);
    chk("rp_wen0", {7'd0, wr_wen}, 8'h00);
    chk("rp_bypass", {2'd0, rd_data}, 8'h1B);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rrf_flag_wr_sched.md
# rrf_flag_wr_sched

Write scheduler for the retirement flag register file. Up to NSLOT retire slots per cycle may retire a flag update for either of two threads, but the flag RRF has a single write port. This block coalesces updates per thread (newest wins) into one pending register per thread, round-robins the single write port between threads, and bypasses pending values onto the architectural flag read path so readers never see stale flags.

## Interface
- DATA_WIDTH, 6, flag word width
- NSLOT, 3, retire slots per cycle; slot 0 is oldest in program order

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ret_en  in  NSLOT  slot i retires a flag write
- ret_thread  in  NSLOT  thread of slot i
- ret_data  in  NSLOT*DATA_WIDTH  flag value of slot i; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_stall  in  1  RRF write port unavailable this cycle
- wr_data  out  DATA_WIDTH  to RRF write0_data
- wr_wen  out  1  to RRF write0_wen
- wr_thread  out  1  to RRF write_thread
- rd_thread  in  1  thread being read
- rrf_rd_data  in  DATA_WIDTH  architectural value from RRF for rd_thread, same cycle
- rd_data  out  DATA_WIDTH  bypassed flag value for rd_thread
- pend  out  2  per-thread pending flag
- idle  out  1  no pending writes

## Operation
- Coalesce, combinational: per thread t, select the highest-index slot with ret_en=1 and ret_thread=t. This gives new_v[t] and new_d[t].
- State:
  - pend_v[1:0]
  - pend_d[1:0][DATA_WIDTH-1:0]
  - rr (1 bit): thread favoured next
- Grant, combinational:
  - No grant when wr_stall=1 or pend_v=0.
  - If exactly one thread is pending, grant that thread.
  - If both are pending, grant thread rr.
- Write port outputs:
  - wr_wen = grant valid.
  - wr_thread = granted thread g.
  - wr_data = pend_d[g].
  - When wr_wen=0, wr_data and wr_thread are 0.
- Pending update per thread t at posedge:
  - If new_v[t]: pend_v[t] ← 1 and pend_d[t] ← new_d[t]. This applies even if t is granted this cycle; the old value goes to the RRF and the new value stays pending.
  - Else if t is granted: pend_v[t] ← 0.
  - Else: hold.
- rr update: on any grant, rr ← ~g. No grant: hold.
- Bypass: rd_data = pend_v[rd_thread] ? pend_d[rd_thread] : rrf_rd_data. The bypass covers pending state only; retires in the current cycle are not visible.
- pend = pend_v. idle = ~|pend_v.

## Timing
- Reset values: pend_v=0, pend_d=0, rr=0. Consequently wr_wen=0, wr_data=0, wr_thread=0, pend=0, idle=1, and rd_data=rrf_rd_data.
- A reset asserted mid-operation discards all pending updates in the same edge.
- Retire in cycle N: pending from N+1.
  - With no conflict and no stall, wr_wen=1 in N+1.
  - The RRF captures the value at the end of N+1; it is architecturally visible from N+2.
  - rd_data returns the new value from N+1.
- Worst-case write latency for a thread with wr_stall=0 is 2 cycles after pending (one round-robin loss).
- Continuous retires to one thread with no stall: one RRF write per cycle, each lagging its retire by 1 cycle.
- No backpressure to retire is needed. An overwritten pending value is architecturally dead because it is older.
- wr_stall held for any duration: state holds except for coalescing; rr holds.

## Structure
- Shared package holds:
  - FLAG_W = 6
  - NTHREAD = 2
  - NSLOT = 3
  - typedef flag_t = logic [FLAG_W-1:0]
- Sub-module rrf_flag_coalesce: pure combinational newest-slot-per-thread selector (ret_* in, new_v/new_d out). Instantiated once.
- Everything else lives in the top level: pending registers, round-robin arbiter, bypass mux.

## Test plan
- Reset, then slot0 retires t0 0x15 in cycle 1 → cycle 2: pend=01, wr_wen=1, wr_thread=0, wr_data=0x15; cycle 3: idle=1.
- Same cycle: slot0 t1 0x01, slot1 t1 0x02, slot2 t0 0x3F → t0 written first (rr=0) with 0x3F, then t1 with 0x02; value 0x01 is never written.
- Both threads pending with rr=1 → t1 granted, rr becomes 0; next cycle t0 granted.
- t0 pending 0x0A and granted while slot1 retires t0 0x0B in the same cycle → wr_data=0x0A, pend_v[0] stays 1 with 0x0B, written the next cycle.
- wr_stall=1 for 4 cycles while t1 retires 0x11, then 0x22 → no writes during the stall; rd_data for t1 reads 0x11, then 0x22; one write of 0x22 after the stall drops.
- Both threads pending, then rst pulsed for one cycle → next cycle pend=0, wr_wen=0, rd_data equals rrf_rd_data.
